pc_gen: RTL

Program-counter generator for the single-cycle RISC-V core; sits directly upstream of the instruction memory and drives its `pc` input. It sequences fetch addresses by +4 and redirects on taken branches and JAL using the decoded `branch` and `jump` flags and the immediate offset fed back from decode. It squashes the two wrong-path fetches already in the instruction memory's two-register pipeline and stops at the end of the program image.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_history.sv | 25 ++
 rtl/pc_gen.sv | 115 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: PC sequencer states, flush depth
// and instruction step.
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } pc_state_t;

  localparam int FLUSH_CYCLES = 2;
  localparam int PC_STEP      = 4;

  function automatic logic is_redirect(input logic branch, input logic branch_taken,
                                       input logic jump);
    return jump | (branch & branch_taken);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Decode-to-fetch interface of the PC generator: redirect flags in, fetch address out.
// The fault output exists only when PC_MISALIGN_TRAP_EN is defined.
interface pc_gen_if #(parameter int WIDTH = 32);

  logic             stall;
  logic             branch;
  logic             branch_taken;
  logic             jump;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             flush;
  logic             halted;
`ifdef PC_MISALIGN_TRAP_EN
  logic             fault;
`endif

  modport master (
    output stall, branch, branch_taken, jump, offset,
`ifdef PC_MISALIGN_TRAP_EN
    input  fault,
`endif
    input  pc, pc_plus4, flush, halted
  );

  modport slave (
    input  stall, branch, branch_taken, jump, offset,
`ifdef PC_MISALIGN_TRAP_EN
    output fault,
`endif
    output pc, pc_plus4, flush, halted
  );

endinterface

// File: rtl/pc_history.sv
// Two-deep enabled delay line tracking the fetch addresses still inside the
// instruction memory pipeline.
module pc_history #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= INIT;
      q2 <= INIT;
    end else if (en) begin
      q1 <= d;
      q2 <= q1;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: +4 sequencing, branch/JAL redirect with 2-cycle squash,
// halt at the program's NO-OP. Define PC_MISALIGN_TRAP_EN to trap misaligned targets.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               NUM_INST = 19
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam logic [1:0]       S_RUN      = RUN;
  localparam logic [1:0]       S_FLUSH    = FLUSH;
  localparam logic [1:0]       S_HALT     = HALT;
  localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_CYCLES);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] NOOP_ADDR  = WIDTH'((NUM_INST - 1) * PC_STEP);

  logic [1:0]       state, state_nx;
  logic [1:0]       cnt, cnt_nx;
  logic [WIDTH-1:0] pc, pc_nx, seq_pc, target;
  logic [WIDTH-1:0] pc_q1_unused, pc_q2;
  logic             redirect, misaligned;

  pc_history #(.WIDTH(WIDTH), .INIT(RESET_PC)) u_history (
    .clk (clk),
    .rst (rst),
    .en  (!bus.stall),
    .d   (pc),
    .q1  (pc_q1_unused),
    .q2  (pc_q2)
  );

  assign seq_pc   = pc + STEP;
  assign redirect = is_redirect(bus.branch, bus.branch_taken, bus.jump);

`ifdef PC_MISALIGN_TRAP_EN
  assign target     = pc_q2 + bus.offset;
  assign misaligned = |target[1:0];
`else
  assign target     = (pc_q2 + bus.offset) & ~WIDTH'(3);
  assign misaligned = 1'b0;
`endif

  // Any next address at or past the NO-OP parks the sequencer in HALT.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    case (state)
      S_RUN: begin
        if (redirect) begin
          if (misaligned) begin
            state_nx = S_HALT;
          end else if (target >= NOOP_ADDR) begin
            pc_nx    = target;
            state_nx = S_HALT;
          end else begin
            pc_nx    = target;
            state_nx = S_FLUSH;
            cnt_nx   = FLUSH_LOAD;
          end
        end else if (seq_pc >= NOOP_ADDR) begin
          pc_nx    = NOOP_ADDR;
          state_nx = S_HALT;
        end else begin
          pc_nx = seq_pc;
        end
      end
      S_FLUSH: begin
        cnt_nx = cnt - 2'd1;
        if (seq_pc >= NOOP_ADDR) begin
          pc_nx    = NOOP_ADDR;
          state_nx = S_HALT;
          cnt_nx   = '0;
        end else begin
          pc_nx = seq_pc;
          if (cnt_nx == 2'd0) state_nx = S_RUN;
        end
      end
      default: begin
        state_nx = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= S_RUN;
      cnt        <= '0;
      bus.flush  <= 1'b0;
      bus.halted <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      bus.fault  <= 1'b0;
`endif
    end else if (!bus.stall) begin
      pc         <= pc_nx;
      state      <= state_nx;
      cnt        <= cnt_nx;
      bus.flush  <= (state_nx == S_FLUSH);
      bus.halted <= (state_nx == S_HALT);
`ifdef PC_MISALIGN_TRAP_EN
      if (state == S_RUN && redirect && misaligned) bus.fault <= 1'b1;
`endif
    end
  end

  assign bus.pc       = pc;
  assign bus.pc_plus4 = seq_pc;

endmodule
